// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults for the register file: word size, register address size and
// the index of the hard-wired zero register.
package regfile_scoreboard_pkg;

    localparam int WORDSIZE    = 64;
    localparam int REGADDRSIZE = 5;
    localparam int XZR         = 31;

    // One-hot decode of a register address, used for pending set/clear masks.
    function automatic logic [(2**REGADDRSIZE)-1:0] addr_onehot(input logic [REGADDRSIZE-1:0] addr);
        logic [(2**REGADDRSIZE)-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_pending.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on
// writeback, with a same-cycle set taking priority over the clear.
module regfile_scoreboard_pending
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDRW   = REGADDRSIZE,
    parameter int ZEROREG = XZR,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDRW-1:0] rn,
    input  logic [ADDRW-1:0] rm,
    input  logic             issue,
    input  logic [ADDRW-1:0] issue_rd,
    input  logic             wren,
    input  logic [ADDRW-1:0] rd,
    output logic             busyn,
    output logic             busym,
    output logic             waw
);

    localparam int               NREG      = 2**ADDRW;
    localparam logic [ADDRW-1:0] ZERO_ADDR = ADDRW'(ZEROREG);
    localparam logic             BYPASS_EN = (BYPASS != 0);

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_next_s;
    logic            wr_hit_s;
    logic            issue_hit_s;

    assign wr_hit_s    = wren  && (rd       != ZERO_ADDR);
    assign issue_hit_s = issue && (issue_rd != ZERO_ADDR);

    // Next pending vector: clear first, then set, so a new producer supersedes the completing one.
    always_comb begin
        pending_next_s = pending_r;
        if (wr_hit_s) begin
            pending_next_s[rd] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (issue_hit_s) begin
            pending_next_s[issue_rd] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[ZERO_ADDR] = 1'b0;
    end

    // Pending state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Hazard flags; a writeback in flight only resolves a read hazard when it is forwarded.
    always_comb begin
        busyn = pending_r[rn] && (rn != ZERO_ADDR) && !(BYPASS_EN && wren && (rd == rn));
        busym = pending_r[rm] && (rm != ZERO_ADDR) && !(BYPASS_EN && wren && (rd == rm));
        waw   = issue_hit_s && pending_r[issue_rd] && !(wren && (rd == issue_rd));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one clocked write port,
// optional write-to-read bypass and a pending-write hazard scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH   = WORDSIZE,
    parameter int ADDRW   = REGADDRSIZE,
    parameter int ZEROREG = XZR,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDRW-1:0] rn,
    input  logic [ADDRW-1:0] rm,
    output logic [WIDTH-1:0] outn,
    output logic [WIDTH-1:0] outm,
    output logic             busyn,
    output logic             busym,
    input  logic             issue,
    input  logic [ADDRW-1:0] issue_rd,
    output logic             waw,
    input  logic [ADDRW-1:0] rd,
    input  logic [WIDTH-1:0] in,
    input  logic             wren
);

    localparam int               NREG      = 2**ADDRW;
    localparam logic [ADDRW-1:0] ZERO_ADDR = ADDRW'(ZEROREG);
    localparam logic             BYPASS_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regs_r [NREG];

    // Data array: writes to the zero register are dropped so its entry stays 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wren && (rd != ZERO_ADDR)) begin
            regs_r[rd] <= in;
        end
    end

    // Read port n: zero register, then same-cycle forward, then stored value.
    always_comb begin
        outn = '0;
        if (rn == ZERO_ADDR) begin
            outn = '0;
        end else if (BYPASS_EN && wren && (rd == rn)) begin
            outn = in;
        end else begin
            outn = regs_r[rn];
        end
    end

    // Read port m: same priority as port n.
    always_comb begin
        outm = '0;
        if (rm == ZERO_ADDR) begin
            outm = '0;
        end else if (BYPASS_EN && wren && (rd == rm)) begin
            outm = in;
        end else begin
            outm = regs_r[rm];
        end
    end

    regfile_scoreboard_pending #(
        .ADDRW   (ADDRW),
        .ZEROREG (ZEROREG),
        .BYPASS  (BYPASS)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .rn       (rn),
        .rm       (rm),
        .issue    (issue),
        .issue_rd (issue_rd),
        .wren     (wren),
        .rd       (rd),
        .busyn    (busyn),
        .busym    (busym),
        .waw      (waw)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the core register file. It has two combinational read ports and one clocked write port, with optional write-to-read bypass. It also holds a per-register pending-write scoreboard so the pipeline can detect RAW and WAW hazards on registers whose producer (e.g. a load) has issued but not yet written back. It sits between decode (reads, issue) and writeback (write).

Parameters:
WIDTH, 64, data word width in bits.
ADDRW, 5, register address width; the file holds 2**ADDRW registers.
ZEROREG, 31, index of the hard-wired zero register (XZR). Must be < 2**ADDRW.
BYPASS, 1, 1 = forward the same-cycle write data to the read ports; 0 = no forwarding.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high.
rn  input  ADDRW  read address, port n.
rm  input  ADDRW  read address, port m.
outn  output  WIDTH  data for register rn.
outm  output  WIDTH  data for register rm.
busyn  output  1  rn has an outstanding pending write.
busym  output  1  rm has an outstanding pending write.
issue  input  1  an instruction writing issue_rd is issued this cycle.
issue_rd  input  ADDRW  destination of the issued instruction.
waw  output  1  issue targets a register that is already pending.
rd  input  ADDRW  writeback address.
in  input  WIDTH  writeback data.
wren  input  1  writeback enable.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset: all registers = 0 and all pending bits = 0 immediately. With ZEROREG as the read address, outn/outm = 0, busyn/busym = 0 and waw = 0.
- Storage: 2**ADDRW x WIDTH register array, plus a 2**ADDRW-bit pending vector. Bit ZEROREG is never stored.
- Write: at posedge, if wren && rd != ZEROREG, then registers[rd] <= in. Writes to ZEROREG are discarded.
- Read (combinational, zero latency):
  - outX = 0 if rX == ZEROREG.
  - Otherwise, if BYPASS && wren && rd == rX, outX = in.
  - Otherwise, outX = registers[rX].
- Pending set: at posedge, if issue && issue_rd != ZEROREG, then pending[issue_rd] <= 1.
- Pending clear: at posedge, if wren && rd != ZEROREG, then pending[rd] <= 0.
- Set and clear in the same cycle on the same index: set wins, because a new producer supersedes the completing one.
- busyX = pending[rX] && rX != ZEROREG && !(BYPASS && wren && rd == rX). A writeback in progress resolves the hazard only when bypass is enabled.
- The same-cycle issue to issue_rd == rX does not raise busyX. The issuing instruction's own sources are read before its destination is marked.
- waw = issue && issue_rd != ZEROREG && pending[issue_rd] && !(wren && rd == issue_rd). The pipeline must stall on waw. The block still sets the bit, because a single bit cannot count multiple producers.
- wren to a register that is not pending: the write is performed and the pending bit stays 0. This is legal for ALU results that are never scoreboarded.
- Reset asserted mid-operation: all state clears regardless of wren/issue. The first posedge after reset deasserts processes inputs normally.

Decomposition:
- WIDTH, ADDRW and ZEROREG defaults come from the shared headers (`WORDSIZE, `REGADDRSIZE, `XZR in bus.vh / registers.vh). No new package is needed; the block adds a `REGPORTS count constant to registers.vh only if more read ports are added later.
- One natural sub-module: regfile_pending. It holds the pending vector with set, clear and set-priority logic, and its outputs feed busyn, busym and waw. The data array and bypass muxes stay in the top level.

Test Plan:
1. Pulse reset with rn=3, rm=31 -> outn=0, outm=0, busyn=busym=0, waw=0.
2. wren=1, rd=5, in=64'hDEAD_BEEF, rn=5, BYPASS=1 -> outn=64'hDEAD_BEEF in the same cycle. After the edge, with wren=0, outn is still 64'hDEAD_BEEF. With BYPASS=0, outn is the old value (0) in the write cycle.
3. wren=1, rd=31, in=64'h1234 -> after the edge, reading rn=31 gives 0. Set issue=1, issue_rd=31 -> busyn stays 0 on rn=31 and waw=0.
4. issue=1, issue_rd=7 at cycle 0 -> at cycle 1 with rn=7, busyn=1. At cycle 3, wren=1, rd=7, in=9 -> busyn=0 in that cycle (BYPASS=1) and outn=9. At cycle 4, busyn=0.
5. With pending[7]=1, drive issue=1, issue_rd=7 and wren=1, rd=7 in one cycle -> waw=0. After the edge, pending[7] is still 1 (set wins) and registers[7]=in.
6. With pending[4]=1, drive issue=1, issue_rd=4, wren=0 -> waw=1. Assert reset mid-cycle -> waw, busyn and busym drop to 0 and registers[4] reads 0.
